// File: rtl/instr_encoder.sv
// instr_encoder
//   Encodes MIPS-style instruction requests into 32-bit words and writes
//   them to consecutive word addresses of an instruction memory.
//   Encoding is combinational at the input. Each accepted word is pushed
//   into a 4-entry FIFO together with its last tag. A four-state FSM
//   (IDLE/RUN/DRAIN/DONE) sequences a load session.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, base_addr    session start pulse and byte base address
//   in_valid/in_ready   request handshake (op_sel, rs, rt, rd, shamt,
//                       imm, target, in_last)
//   imem_we/imem_ready  memory write handshake (imem_addr, imem_wdata)
//   busy, done          FSM not idle / one-cycle completion pulse
//   words_written       completed writes in the current session
//   err_illegal         sticky illegal-op flag (ENC_ERR_CHECK_EN only)
//
// Configuration macro: ENC_ERR_CHECK_EN
//   defined   : illegal op_sel is accepted, dropped, and sets err_illegal
//   undefined : illegal op_sel encodes as a NOP (0) and is pushed
module instr_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  op_sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  input  logic        in_last,
  output logic        imem_we,
  input  logic        imem_ready,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] words_written
`ifdef ENC_ERR_CHECK_EN
  ,
  output logic        err_illegal
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t      state_q;
  logic [31:0] addr_q;
  logic [15:0] words_q;
  logic        done_q;
  logic        err_q;
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q, count_d;
  logic [32:0] fifo_q [4];  // {last, word}

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        accept, push, pop;
  logic        fifo_empty, fifo_full;
  logic [32:0] head;

  // Word alignment: the low address bits are discarded.
  logic unused_base_bits;
  assign unused_base_bits = ^base_addr[1:0];

  // Combinational instruction encoder.
  always_comb begin
    enc_word  = 32'h0000_0000;
    enc_legal = 1'b1;
    case (op_sel)
      5'd0:  enc_word = {6'b0, rs, rt, rd, 5'd0,  6'b100100};  // AND
      5'd1:  enc_word = {6'b0, rs, rt, rd, 5'd0,  6'b100101};  // OR
      5'd2:  enc_word = {6'b0, rs, rt, rd, 5'd0,  6'b100000};  // ADD
      5'd3:  enc_word = {6'b0, rs, rt, rd, 5'd0,  6'b100110};  // XOR
      5'd4:  enc_word = {6'b0, rs, rt, rd, 5'd0,  6'b100111};  // NOR
      5'd5:  enc_word = {6'b0, rs, rt, rd, shamt, 6'b000010};  // SRL
      5'd6:  enc_word = {6'b0, rs, rt, rd, 5'd0,  6'b100010};  // SUB
      5'd7:  enc_word = {6'b0, rs, rt, rd, shamt, 6'b000000};  // SLL
      5'd8:  enc_word = {6'b0, rs, rt, rd, 5'd0,  6'b100001};  // ADDU
      5'd9:  enc_word = {6'b0, rs, rt, rd, 5'd0,  6'b100011};  // SUBU
      5'd10: enc_word = {6'b0, rs, 15'b0, 6'b001000};          // JR
      5'd11: enc_word = {6'b001100, rs, rt, imm};              // ANDI
      5'd12: enc_word = {6'b001101, rs, rt, imm};              // ORI
      5'd13: enc_word = {6'b001000, rs, rt, imm};              // ADDI
      5'd14: enc_word = {6'b100011, rs, rt, imm};              // LW
      5'd15: enc_word = {6'b101011, rs, rt, imm};              // SW
      5'd16: enc_word = {6'b000100, rs, rt, imm};              // BEQ
      5'd17: enc_word = {6'b000101, rs, rt, imm};              // BNE
      5'd18: enc_word = {6'b000110, rs, rt, imm};              // BLT
      5'd19: enc_word = {6'b000111, rs, rt, imm};              // BGT
      5'd20: enc_word = {6'b001010, rs, rt, imm};              // BLE
      5'd21: enc_word = {6'b001011, rs, rt, imm};              // BGE
      5'd22: enc_word = {6'b000011, target};                   // JAL
      default: enc_legal = 1'b0;                               // NOP word
    endcase
  end

  assign fifo_empty = (count_q == 3'd0);
  assign fifo_full  = (count_q == 3'd4);

  // No bypass: a full FIFO refuses input even when it pops this cycle.
  assign in_ready = (state_q == S_RUN) && !fifo_full;
  assign accept   = in_valid && in_ready;
`ifdef ENC_ERR_CHECK_EN
  assign push = accept && enc_legal;
`else
  assign push = accept;
`endif
  assign imem_we = !fifo_empty;
  assign pop     = imem_we && imem_ready;

  assign head          = fifo_q[rd_ptr_q];
  assign imem_wdata    = fifo_empty ? 32'h0000_0000 : head[31:0];
  assign imem_addr     = addr_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign words_written = words_q;
`ifdef ENC_ERR_CHECK_EN
  assign err_illegal = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 3'd1;
    else if (pop && !push) count_d = count_q - 3'd1;
  end

  // FIFO storage, one register per entry.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fifo
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          fifo_q[gi] <= 33'h0;
        else if (push && (wr_ptr_q == gi[1:0]))
          fifo_q[gi] <= {in_last, enc_word};
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= 32'h0;
      words_q  <= 16'h0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      done_q  <= 1'b0;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
        addr_q   <= addr_q + 32'd4;   // wraps naturally at 2^32
        words_q  <= words_q + 16'd1;  // wraps naturally at 2^16
      end
`ifdef ENC_ERR_CHECK_EN
      if (accept && !enc_legal) err_q <= 1'b1;
`endif
      case (state_q)
        S_IDLE: if (start) begin
          state_q <= S_RUN;
          addr_q  <= {base_addr[31:2], 2'b00};
          words_q <= 16'h0;
          err_q   <= 1'b0;
        end
        S_RUN: if (accept && in_last) state_q <= S_DRAIN;
        // The empty case covers a dropped illegal last request, which
        // leaves no tagged entry behind.
        S_DRAIN: if ((pop && head[32]) || fifo_empty) begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;  // S_DONE
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op_sel = '0, rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;
  logic        in_last = 1'b0;
  logic        imem_we;
  logic        imem_ready = 1'b1;
  logic [31:0] imem_addr, imem_wdata;
  logic        busy, done;
  logic [15:0] words_written;
`ifdef ENC_ERR_CHECK_EN
  logic        err_illegal;
`endif

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .op_sel(op_sel),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm), .target(target),
    .in_last(in_last), .imem_we(imem_we), .imem_ready(imem_ready),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy),
    .done(done), .words_written(words_written)
`ifdef ENC_ERR_CHECK_EN
    , .err_illegal(err_illegal)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model state.
  logic [63:0] exp_q[$];     // {addr, word} expected on the imem bus
  logic [63:0] wr_log[$];    // writes observed in the current session
  logic [31:0] exp_addr;
  int          exp_words;
  logic        exp_err;
  logic        ready_ctl = 1'b1;
  logic        rand_ready = 1'b0;

  localparam logic [5:0] RFUNCT [0:9] = '{6'b100100, 6'b100101, 6'b100000,
    6'b100110, 6'b100111, 6'b000010, 6'b100010, 6'b000000, 6'b100001, 6'b100011};
  localparam logic [5:0] IOPC [0:10] = '{6'b001100, 6'b001101, 6'b001000,
    6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000110, 6'b000111,
    6'b001010, 6'b001011};

  // Returns {legal, word} from the mnemonic table.
  function automatic logic [32:0] ref_encode(input int op, input logic [4:0] s, t, d, sa,
                                             input logic [15:0] im, input logic [25:0] tg);
    if (op < 10)  return {1'b1, 6'b0, s, t, d, (op == 5 || op == 7) ? sa : 5'd0, RFUNCT[op]};
    if (op == 10) return {1'b1, 6'b0, s, 15'b0, 6'b001000};
    if (op < 22)  return {1'b1, IOPC[op - 11], s, t, im};
    if (op == 22) return {1'b1, 6'b000011, tg};
    return 33'h0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // imem_ready driver: directed level or random back-pressure.
  always @(posedge clk) begin
    #2;
    imem_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_ctl;
  end

  // Write monitor: every completed write must match the model queue head.
  always @(negedge clk) begin
    if (rst_n && imem_we && imem_ready) begin
      $display("write addr=%h data=%h", imem_addr, imem_wdata);
      wr_log.push_back({imem_addr, imem_wdata});
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_write observed=%h_%h expected=none", imem_addr, imem_wdata);
      end
      if (exp_q.size() != 0) begin
        logic [63:0] e;
        e = exp_q.pop_front();
        total++;
        assert ({imem_addr, imem_wdata} === e) else begin
          bad++;
          $error("FAIL write_data observed=%h_%h expected=%h", imem_addr, imem_wdata, e);
        end
      end
    end
  end

  task automatic do_start(input logic [31:0] b);
    base_addr = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_addr = {b[31:2], 2'b00};
    exp_words = 0;
    exp_err = 1'b0;
    wr_log.delete();
    $display("start base=%h", b);
  endtask

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input int op, input logic [4:0] s, t, d, sa,
                      input logic [15:0] im, input logic [25:0] tg,
                      input logic last, input int gap);
    int n;
    logic [32:0] r;
    for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
    op_sel = 5'(op); rs = s; rt = t; rd = d; shamt = sa; imm = im; target = tg;
    in_last = last; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("accept_wait", in_ready, 1'b1);
    if (in_ready === 1'b1) begin
      r = ref_encode(op, s, t, d, sa, im, tg);
      $display("accept op=%0d last=%0d word=%h", op, last, r[31:0]);
`ifdef ENC_ERR_CHECK_EN
      if (!r[32]) exp_err = 1'b1;
      else begin
        exp_q.push_back({exp_addr, r[31:0]}); exp_addr += 32'd4; exp_words++;
      end
`else
      exp_q.push_back({exp_addr, r[31:0]}); exp_addr += 32'd4; exp_words++;
`endif
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (done !== 1'b1 && n < 300);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_words"}, words_written, 16'(exp_words));
    chk({tag, "_drained"}, exp_q.size(), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_idle"}, busy, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    chk("rst_we", imem_we, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_wdata", imem_wdata, 32'h0);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_words", words_written, 16'h0);
`ifdef ENC_ERR_CHECK_EN
    chk("rst_err", err_illegal, 1'b0);
`endif
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // in_valid while idle is ignored
    in_valid = 1'b1; in_last = 1'b1; op_sel = 5'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_ready", in_ready, 1'b0);
      chk("idle_we", imem_we, 1'b0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;

    // Single ADD
    do_start(32'h0000_0100);
    chk("busy_run", busy, 1'b1);
    send(2, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1, 0);
    wait_done("add");
    chk("add_log", wr_log.size() == 1 ? wr_log[0] : 64'h0, {32'h100, 32'h00221820});

    // SLL, BEQ, JAL at consecutive addresses
    do_start(32'h0000_0200);
    send(7,  5'd0, 5'd2, 5'd4, 5'd3, 16'h0, 26'h0, 1'b0, 0);
    send(16, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b0, 0);
    send(22, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000010, 1'b1, 0);
    wait_done("seq3");
    chk("seq3_cnt", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      chk("seq3_w0", wr_log[0], {32'h200, 32'h000220C0});
      chk("seq3_w1", wr_log[1], {32'h204, 32'h1022FFFF});
      chk("seq3_w2", wr_log[2], {32'h208, 32'h0C000010});
    end

    // Back-pressure: FIFO fills at 4, then drains 6 in order
    ready_ctl = 1'b0;
    do_start(32'h0000_1000);
    for (int i = 0; i < 4; i++)
      send(13, 5'(i), 5'(i + 1), 5'd0, 5'd0, 16'(i * 7), 26'h0, 1'b0, 0);
    in_valid = 1'b1; op_sel = 5'd11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_ready", in_ready, 1'b0);
      chk("full_we", imem_we, 1'b1);
      chk("hold_head", {imem_addr, imem_wdata}, exp_q[0]);
    end
    chk("full_words", words_written, 16'h0);
    @(posedge clk); #1;
    ready_ctl = 1'b1;
    send(11, 5'd9, 5'd8, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b0, 0);
    send(12, 5'd7, 5'd6, 5'd0, 5'd0, 16'h00FF, 26'h0, 1'b1, 0);
    wait_done("bp6");
    chk("bp6_cnt", wr_log.size(), 6);

    // Address wrap; low base bits ignored
    do_start(32'hFFFF_FFFF);
    send(14, 5'd3, 5'd4, 5'd0, 5'd0, 16'h0010, 26'h0, 1'b0, 0);
    send(15, 5'd3, 5'd5, 5'd0, 5'd0, 16'h0020, 26'h0, 1'b1, 0);
    wait_done("wrap");
    chk("wrap_cnt", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("wrap_a0", wr_log[0][63:32], 32'hFFFF_FFFC);
      chk("wrap_a1", wr_log[1][63:32], 32'h0000_0000);
    end

    // Illegal op with last
    do_start(32'h0000_0500);
    send(25, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 1'b1, 0);
    wait_done("illegal");
`ifdef ENC_ERR_CHECK_EN
    chk("illegal_nowrite", wr_log.size(), 0);
    chk("illegal_err", err_illegal, 1'b1);
    do_start(32'h0000_0600);
    chk("err_clear", err_illegal, 1'b0);
    send(0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1, 0);
    wait_done("after_err");
`else
    chk("illegal_nop", wr_log.size() == 1 ? wr_log[0] : 64'hDEAD, {32'h500, 32'h0});
`endif

    // Reset mid-session with 3 words queued
    ready_ctl = 1'b0;
    do_start(32'h0000_0300);
    for (int i = 0; i < 3; i++)
      send(1, 5'(i), 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0, 0);
    @(negedge clk);
    chk("pre_rst_we", imem_we, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_we", imem_we, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_words", words_written, 16'h0);
    chk("mid_rst_ready", in_ready, 1'b0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    exp_q.delete();
    ready_ctl = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_we", imem_we, 1'b0);
    end
    @(posedge clk); #1;
    do_start(32'h0000_0400);
    send(3, 5'd5, 5'd6, 5'd7, 5'd0, 16'h0, 26'h0, 1'b0, 0);
    send(4, 5'd8, 5'd9, 5'd10, 5'd0, 16'h0, 26'h0, 1'b1, 0);
    wait_done("post_rst");

    // Randomized sessions with random back-pressure
    rand_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      do_start($urandom);
      for (int i = 0; i < 10; i++) begin
        if (s == 0 && i == 3) begin
          // start during RUN must be ignored
          base_addr = 32'hDEAD_0000; start = 1'b1;
          @(posedge clk); #1;
          start = 1'b0;
          chk("start_ignored_busy", busy, 1'b1);
        end
        send(int'($urandom_range(0, 24)), 5'($urandom), 5'($urandom), 5'($urandom),
             5'($urandom), 16'($urandom), 26'($urandom), i == 9, int'($urandom_range(0, 2)));
      end
      wait_done("rand");
`ifdef ENC_ERR_CHECK_EN
      chk("rand_err", err_illegal, exp_err);
`endif
    end
    rand_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
